fifo_width_packer: RTL
======================

Name: fifo_width_packer

Overview:
- Downstream consumer of shift_register_fifo: drains the FIFO through its push/pop/empty interface and packs RATIO consecutive WIDTH-bit words into one wide beat.
- Presents each wide beat on a valid/ready output.
- Drives pop only when the FIFO is non-empty, so the FIFO's no-pop-when-empty environment constraint always holds.
- Supports flush of a partial beat, with a word count.

Parameters:
- WIDTH, 8, FIFO word width in bits.
- RATIO, 4, FIFO words per output beat; legal values 2..16.
- CW, $clog2(RATIO+1), width of out_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO head word; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_pop  output  1  pops the FIFO head this cycle.
- flush  input  1  single-cycle request to emit any partial beat.
- out_valid  output  1  out_data/out_count hold a beat.
- out_ready  input  1  consumer accepts the beat when out_valid&out_ready.
- out_data  output  WIDTH*RATIO  packed beat; first popped word in bits [WIDTH-1:0].
- out_count  output  CW  number of valid words in the beat, 1..RATIO.

Behaviour:
- States: FILL (accumulating) and HOLD (beat presented).
- Registers: lane index idx (0..RATIO-1), accumulator acc, out_count.
- Reset (rst=0, asynchronous): state=FILL, idx=0, acc=0, out_valid=0, out_count=0, out_data=0, fifo_pop=0 (fifo_pop is combinational and gated by state).
- fifo_pop = !fifo_empty && (state==FILL || out_ready). It is never 1 while fifo_empty=1.
- FILL, pop: acc lane idx <= fifo_data.
  - If idx==RATIO-1: go to HOLD, out_count=RATIO, idx=0.
  - Otherwise idx <= idx+1.
- FILL, flush with idx>0 or pop:
  - Go to HOLD with out_count = idx + pop (the word popped in this cycle is included).
  - Unfilled lanes are zero.
  - idx=0.
- Flush with idx==0 and no pop: no effect.
- Flush in HOLD: ignored. The team's contract is that flush is not issued while out_valid=1.
- HOLD: out_valid=1; out_data and out_count are stable until accepted.
- HOLD with out_ready=1:
  - The beat transfers.
  - If a pop also occurs, go to FILL with lane 0 loaded from fifo_data and idx=1. This gives full throughput: one pop per cycle at steady state with out_ready held high.
  - If RATIO words are popped back-to-back, the transfer and the lane-0 capture coincide.
  - Without a pop: go to FILL, idx=0.
- On leaving HOLD, all lanes not written in that cycle are cleared.
- Latency: the word popped at cycle t appears at out_data no earlier than t+1. A beat completes out_valid one cycle after its last pop.
- No words are dropped or duplicated:
  - Every pop lands in exactly one beat.
  - Beat order equals FIFO pop order.
- Reset asserted mid-beat: partial acc is discarded and the FIFO is not popped during reset.
  - The FIFO shares the reset, so the FIFO and packer stay consistent.
- No arithmetic overflow: idx saturates at RATIO-1 by construction; out_count never exceeds RATIO.

Decomposition:
- Package fast_pack_pkg:
  - enum state_t {FILL, HOLD};
  - function lane_mask(idx) returning a one-hot lane select.
  - localparam helper for CW.
- One sub-module is natural: pack_lane_reg (one WIDTH-bit lane with load and clear), instantiated RATIO times via generate.
- The FSM, index counter and pop gating stay in fifo_width_packer.
- A formal wrapper pairs this block with shift_register_fifo and the SimpleScoreboard, checking the same data integrity property on unpacked lanes. It also asserts fifo_pop -> !fifo_empty.

Test Plan (WIDTH=8, RATIO=4):
- Reset then FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 → 4 pops on consecutive cycles; one beat out_data=0x44332211, out_count=4, out_valid high for 1 cycle.
- 8 words 0x01..0x08 continuous, out_ready=1 → fifo_pop high 8 consecutive cycles; beats 0x04030201 then 0x08070605, no bubble between them.
- Words 0xAA,0xBB then flush with FIFO empty → beat out_data=0x0000BBAA, out_count=2; next beat starts at lane 0.
- Full beat pending, out_ready=0 for 5 cycles with FIFO non-empty → fifo_pop=0, out_data stable; first cycle out_ready=1 pops next word into lane 0.
- FIFO empty throughout, random out_ready/flush → fifo_pop never 1, out_valid never 1.
- rst low after 3 of 4 words → out_valid=0, idx=0 immediately (asynchronous); after release, the next 4 words form a clean beat with no stale lanes.

Source files
------------

// File: rtl/fast_pack_pkg.sv
// Shared types and helpers for the FIFO width packer.
package fast_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned MAX_RATIO = 16;
    localparam int unsigned IDX_W     = 4;

    // Width needed to hold a word count in 0..ratio.
    function automatic int unsigned cw_for(input int unsigned ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic logic [MAX_RATIO-1:0] lane_mask(input logic [IDX_W-1:0] idx);
        return MAX_RATIO'(1) << idx;
    endfunction

endpackage

// File: rtl/pack_lane_reg.sv
// One WIDTH-bit accumulator lane; load has priority over clear.
module pack_lane_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_clr) begin
            r_q <= '0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fifo_width_packer.sv
// Drains a first-word-fall-through FIFO and packs RATIO words per output beat,
// with flush of a partial beat and full throughput under continuous out_ready.
module fifo_width_packer
    import fast_pack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned CW    = cw_for(RATIO)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_fifo_empty,
    input  logic [WIDTH-1:0]       i_fifo_data,
    output logic                   o_fifo_pop,
    input  logic                   i_flush,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH*RATIO-1:0] o_out_data,
    output logic [CW-1:0]          o_out_count
);

    localparam int unsigned IW   = $clog2(RATIO);
    localparam int unsigned LAST = RATIO - 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          w_idx_nxt;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   w_pop;
    logic                   w_clr;
    logic [RATIO-1:0]       w_load;
    logic [RATIO-1:0]       w_mask_idx;
    logic [RATIO-1:0]       w_mask_zero;
    logic [WIDTH*RATIO-1:0] w_acc;

    assign w_mask_idx  = RATIO'(lane_mask(IDX_W'(r_idx)));
    assign w_mask_zero = RATIO'(lane_mask(IDX_W'(0)));

    // Pop only with data present, never in reset, and in HOLD only when the beat leaves.
    assign w_pop = i_rst & ~i_fifo_empty & ((r_state == FILL) | i_out_ready);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_valid_nxt = r_valid;
        w_load      = '0;
        w_clr       = 1'b0;
        case (r_state)
            FILL: begin
                if (w_pop) begin
                    w_load = w_mask_idx;
                    if ((r_idx == IW'(LAST)) || i_flush) begin
                        w_state_nxt = HOLD;
                        w_valid_nxt = 1'b1;
                        w_count_nxt = CW'(r_idx) + CW'(1);
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else if (i_flush && (r_idx != '0)) begin
                    w_state_nxt = HOLD;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = CW'(r_idx);
                    w_idx_nxt   = '0;
                end
            end
            HOLD: begin
                // Beat leaves; a same-cycle pop restarts the next beat at lane 0.
                if (i_out_ready) begin
                    w_state_nxt = FILL;
                    w_valid_nxt = 1'b0;
                    w_count_nxt = '0;
                    w_clr       = 1'b1;
                    if (w_pop) begin
                        w_load    = w_mask_zero;
                        w_idx_nxt = IW'(1);
                    end else begin
                        w_idx_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_idx   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    for (genvar g = 0; g < int'(RATIO); g++) begin : g_lane
        pack_lane_reg #(
            .WIDTH(WIDTH)
        ) u_lane (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_load(w_load[g]),
            .i_clr (w_clr),
            .i_d   (i_fifo_data),
            .o_q   (w_acc[g*WIDTH +: WIDTH])
        );
    end

    assign o_fifo_pop  = w_pop;
    assign o_out_valid = r_valid;
    assign o_out_data  = w_acc;
    assign o_out_count = r_count;

endmodule
